// File: rtl/sram_port_arbiter.sv
// Arbitrates one SRAM-style memory port between instruction fetch and load/store,
// running each transfer through an address phase and a data phase.
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    input  logic              data_req,
    input  logic [STRB_W-1:0] data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ADDR = 3'd1,
        D_DATA = 3'd2,
        I_ADDR = 3'd3,
        I_DATA = 3'd4
    } state_t;

    state_t state_r;
    logic   last_grant_r;   // 1 = data owned the most recent grant
    logic   inst_elig_s;
    logic   data_elig_s;
    logic   grant_inst_s;
    logic   grant_data_s;
    logic   owner_data_s;
    logic   in_addr_s;
    logic   in_data_s;
    logic   finish_s;

    // Arbitration and transfer-completion decode
    always_comb begin
        inst_elig_s  = inst_req & ~inst_done;
        data_elig_s  = data_req & ~data_done;
        grant_inst_s = inst_elig_s & (~data_elig_s | last_grant_r);
        grant_data_s = data_elig_s & ~grant_inst_s;
        owner_data_s = (state_r == D_ADDR) || (state_r == D_DATA);
        in_addr_s    = (state_r == D_ADDR) || (state_r == I_ADDR);
        in_data_s    = (state_r == D_DATA) || (state_r == I_DATA);
        // A same-cycle addr_ok/data_ok in the address phase finishes the transfer outright
        finish_s     = (in_addr_s & mem_addr_ok & mem_data_ok) | (in_data_s & mem_data_ok);
    end

    // Port sequencer with registered memory-side and requester-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b0;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wstrb    <= {STRB_W{1'b0}};
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            inst_rdata   <= {DATA_W{1'b0}};
            data_rdata   <= {DATA_W{1'b0}};
            inst_done    <= 1'b0;
            data_done    <= 1'b0;
        end else begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
            if (finish_s) begin
                if (owner_data_s) begin
                    data_done <= 1'b1;
                    if (!mem_wr) begin
                        data_rdata <= mem_rdata;
                    end else begin
                        data_rdata <= data_rdata;
                    end
                end else begin
                    inst_done  <= 1'b1;
                    inst_rdata <= mem_rdata;
                end
            end else begin
                inst_rdata <= inst_rdata;
            end
            case (state_r)
                IDLE: begin
                    if (grant_data_s) begin
                        mem_addr     <= data_addr;
                        mem_wstrb    <= data_wen;
                        mem_wr       <= |data_wen;
                        mem_wdata    <= data_wdata;
                        mem_req      <= 1'b1;
                        last_grant_r <= 1'b1;
                        state_r      <= D_ADDR;
                    end else if (grant_inst_s) begin
                        mem_addr     <= inst_addr;
                        mem_wstrb    <= {STRB_W{1'b0}};
                        mem_wr       <= 1'b0;
                        mem_wdata    <= {DATA_W{1'b0}};
                        mem_req      <= 1'b1;
                        last_grant_r <= 1'b0;
                        state_r      <= I_ADDR;
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                D_ADDR, I_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        if (mem_data_ok) begin
                            state_r <= IDLE;
                        end else if (state_r == D_ADDR) begin
                            state_r <= D_DATA;
                        end else begin
                            state_r <= I_DATA;
                        end
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                D_DATA, I_DATA: begin
                    if (mem_data_ok) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign stallreq = (inst_req & ~inst_done) | (data_req & ~data_done);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of requesters, arbitration and memory.
module tb_sram_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req, data_req, mem_addr_ok, mem_data_ok;
    logic [AW-1:0] inst_addr, data_addr;
    logic [SW-1:0] data_wen;
    logic [DW-1:0] data_wdata, mem_rdata;
    logic [DW-1:0] inst_rdata, data_rdata, mem_wdata;
    logic          inst_done, data_done, mem_req, mem_wr, stallreq;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_done(data_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .stallreq(stallreq)
    );

    int checks = 0;
    int errors = 0;

    // Requester intent
    bit          i_act, d_act;
    logic [31:0] i_addr_v, d_addr_v, d_wdata_v;
    logic [3:0]  d_wen_v;

    // Transaction-level model
    bit          inflight, aphase, own_data, last_data, exp_idone, exp_ddone;
    logic [31:0] exp_irdata, exp_drdata, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    bit          owners[$];
    logic [31:0] saved;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight = 1'b0; aphase = 1'b0; own_data = 1'b0; last_data = 1'b0;
        exp_idone = 1'b0; exp_ddone = 1'b0; exp_irdata = 32'h0; exp_drdata = 32'h0;
        i_act = 1'b0; d_act = 1'b0;
    endtask

    // Advance to the next cycle and compare registered outputs with the model
    task automatic tick();
        @(posedge clk); #1;
        chk("inst_done", 64'(inst_done), 64'(exp_idone));
        chk("data_done", 64'(data_done), 64'(exp_ddone));
        chk("inst_rdata", 64'(inst_rdata), 64'(exp_irdata));
        chk("data_rdata", 64'(data_rdata), 64'(exp_drdata));
        chk("mem_req", 64'(mem_req), 64'(aphase));
        if (aphase) begin
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
            chk("mem_wr", 64'(mem_wr), 64'(e_wstrb != 4'h0));
            if (own_data) chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        end
    endtask

    // Drive this cycle's inputs, check stallreq, then advance the model
    task automatic respond(input bit aok, input bit dok, input logic [31:0] rd);
        bit ie, de, own;
        inst_req = i_act; inst_addr = i_addr_v;
        data_req = d_act; data_addr = d_addr_v; data_wen = d_wen_v; data_wdata = d_wdata_v;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
        #1;
        chk("stallreq", 64'(stallreq), 64'((i_act && !exp_idone) || (d_act && !exp_ddone)));
        ie = i_act && !exp_idone;
        de = d_act && !exp_ddone;
        exp_idone = 1'b0;
        exp_ddone = 1'b0;
        if (!inflight) begin
            if (ie || de) begin
                own = (ie && de) ? !last_data : de;
                owners.push_back(own);
                last_data = own; own_data = own; inflight = 1'b1; aphase = 1'b1;
                e_addr  = own ? d_addr_v : i_addr_v;
                e_wstrb = own ? d_wen_v : 4'h0;
                e_wdata = d_wdata_v;
            end
        end else if ((aphase && aok && dok) || (!aphase && dok)) begin
            inflight = 1'b0; aphase = 1'b0;
            if (own_data) begin
                exp_ddone = 1'b1;
                if (e_wstrb == 4'h0) exp_drdata = rd;
            end else begin
                exp_idone  = 1'b1;
                exp_irdata = rd;
            end
        end else if (aphase && aok) begin
            aphase = 1'b0;
        end
    endtask

    task automatic mem_auto(input bit rnd);
        bit aok, dok;
        if (rnd) begin
            aok = aphase && (($urandom % 2) == 1);
            dok = inflight && (aphase ? (aok && (($urandom % 3) == 0)) : (($urandom % 2) == 1));
        end else begin
            aok = aphase;
            dok = inflight && !aphase;
        end
        respond(aok, dok, 32'($urandom));
    endtask

    task automatic req_auto(input bit rnd, input bit allow_new);
        if (exp_idone) i_act = 1'b0;
        if (exp_ddone) d_act = 1'b0;
        if (allow_new && !i_act && (!rnd || ($urandom % 3) == 0)) begin
            i_act = 1'b1; i_addr_v = 32'($urandom);
        end
        if (allow_new && !d_act && (!rnd || ($urandom % 3) == 0)) begin
            d_act = 1'b1; d_addr_v = 32'($urandom); d_wdata_v = 32'($urandom);
            d_wen_v = (($urandom % 2) == 1) ? 4'h0 : 4'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_addr = 32'h0;
        data_wen = 4'h0; data_wdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        i_addr_v = 32'h0; d_addr_v = 32'h0; d_wdata_v = 32'h0; d_wen_v = 4'h0;
        e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_inst_done", 64'(inst_done), 64'(0));

        // Single zero-wait fetch
        tick(); i_act = 1'b1; i_addr_v = 32'hBFC00000; respond(1'b0, 1'b0, 32'h0);
        chk("tp1_stall_c0", 64'(stallreq), 64'(1));
        tick(); respond(1'b1, 1'b0, 32'h0);
        chk("tp1_memreq_c1", 64'(mem_req), 64'(1));
        chk("tp1_addr_c1", 64'(mem_addr), 64'(32'hBFC00000));
        tick(); respond(1'b0, 1'b1, 32'h3C1D0001);
        chk("tp1_memreq_c2", 64'(mem_req), 64'(0));
        tick();
        chk("tp1_done_c3", 64'(inst_done), 64'(1));
        chk("tp1_rdata_c3", 64'(inst_rdata), 64'(32'h3C1D0001));
        i_act = 1'b0; respond(1'b0, 1'b0, 32'h0);
        chk("tp1_stall_c3", 64'(stallreq), 64'(0));

        // Simultaneous requests: data first, then alternation
        owners.delete();
        tick(); i_act = 1'b1; i_addr_v = 32'h00400000;
        d_act = 1'b1; d_addr_v = 32'h80001000; d_wen_v = 4'h0; d_wdata_v = 32'h0;
        mem_auto(1'b0);
        for (int k = 0; k < 12; k++) begin tick(); req_auto(1'b0, 1'b1); mem_auto(1'b0); end
        for (int k = 0; k < 20; k++) begin tick(); req_auto(1'b0, 1'b0); mem_auto(1'b0); end
        chk("tp2_grants", 64'(owners.size() >= 4), 64'(1));
        for (int k = 0; k < 4; k++) chk("tp2_order", 64'(owners[k]), 64'((k % 2) == 0));

        // Store held in the address phase for three cycles
        tick(); d_act = 1'b1; d_addr_v = 32'h80000004; d_wen_v = 4'b0011; d_wdata_v = 32'h12345678;
        saved = exp_drdata;
        respond(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick(); respond(1'b0, 1'b0, 32'h0);
            chk("tp3_wr", 64'(mem_wr), 64'(1));
            chk("tp3_wstrb", 64'(mem_wstrb), 64'(4'b0011));
            chk("tp3_wdata", 64'(mem_wdata), 64'(32'h12345678));
        end
        tick(); respond(1'b1, 1'b0, 32'h0);
        tick(); respond(1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        chk("tp3_done", 64'(data_done), 64'(1));
        chk("tp3_rdata_kept", 64'(data_rdata), 64'(saved));
        d_act = 1'b0; respond(1'b0, 1'b0, 32'h0);
        tick(); respond(1'b0, 1'b0, 32'h0);

        // addr_ok and data_ok together on the first mem_req cycle
        tick(); i_act = 1'b1; i_addr_v = 32'h00001234; respond(1'b0, 1'b0, 32'h0);
        tick(); respond(1'b1, 1'b1, 32'hA5A55A5A);
        tick();
        chk("tp4_done_2cyc", 64'(inst_done), 64'(1));
        chk("tp4_rdata", 64'(inst_rdata), 64'(32'hA5A55A5A));
        i_act = 1'b0; respond(1'b0, 1'b0, 32'h0);

        // Reset during the fetch data phase, late data_ok afterwards
        tick(); i_act = 1'b1; i_addr_v = 32'h00002000; respond(1'b0, 1'b0, 32'h0);
        tick(); respond(1'b1, 1'b0, 32'h0);
        tick(); respond(1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_inst_rdata", 64'(inst_rdata), 64'(0));
        chk("rst_async_data_rdata", 64'(data_rdata), 64'(0));
        chk("rst_async_mem", 64'({mem_req, mem_wr, mem_wstrb}), 64'(0));
        chk("rst_async_addr", 64'(mem_addr), 64'(0));
        chk("rst_async_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_async_done", 64'({inst_done, data_done}), 64'(0));
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        respond(1'b0, 1'b1, 32'h11111111);
        tick();
        chk("tp5_no_done", 64'(inst_done), 64'(0));
        respond(1'b0, 1'b0, 32'h0);
        tick(); i_act = 1'b1; i_addr_v = 32'h00003000; respond(1'b0, 1'b0, 32'h0);
        tick(); respond(1'b1, 1'b0, 32'h0);
        tick(); respond(1'b0, 1'b1, 32'h22222222);
        tick();
        chk("tp5_new_done", 64'(inst_done), 64'(1));
        i_act = 1'b0; respond(1'b0, 1'b0, 32'h0);

        // Randomized traffic with random memory wait states
        for (int k = 0; k < 400; k++) begin tick(); req_auto(1'b1, 1'b1); mem_auto(1'b1); end
        for (int k = 0; k < 30; k++) begin tick(); req_auto(1'b0, 1'b0); mem_auto(1'b0); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one unified SRAM-style memory port between the core's instruction-fetch requester and its load/store requester.
- Sequences each transfer through an address phase and a data phase, then returns read data to the owning requester.
- Raises a stall request toward the pipeline controller while any accepted request is still in flight.
- Sits between the IF/EX/MEM stages and the external memory bridge.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- STRB_W, 4, byte write-enable width (DATA_W/8).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; held with inst_addr until inst_done.
- inst_addr  in  ADDR_W  fetch address.
- inst_rdata  out  DATA_W  fetched word; valid when inst_done=1.
- inst_done  out  1  one-cycle completion pulse for fetch.
- data_req  in  1  load/store request; held with payload until data_done.
- data_wen  in  STRB_W  byte enables; 0 = load.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load word; valid when data_done=1.
- data_done  out  1  one-cycle completion pulse for load/store.
- mem_req  out  1  address-phase request on the shared port.
- mem_wr  out  1  1 = write (OR-reduction of latched wen).
- mem_wstrb  out  STRB_W  latched byte enables.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_addr_ok  in  1  memory accepted the address phase.
- mem_data_ok  in  1  memory completed the data phase.
- mem_rdata  in  DATA_W  read data; valid with mem_data_ok.
- stallreq  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (asynchronous, any cycle):
  - state=IDLE; mem_req, mem_wr, inst_done, data_done = 0.
  - mem_wstrb, mem_addr, mem_wdata, inst_rdata, data_rdata = 0.
  - An in-flight memory transaction is abandoned; a late mem_data_ok after reset is ignored.
- States: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA. Every output except stallreq is registered.
- Arbitration in IDLE:
  - Eligible requester = req high AND its done output is low that cycle, so a just-finished requester is masked for one cycle.
  - Data has priority, except when the last grant was data and inst is eligible; then inst wins (alternation, no inst starvation).
  - A one-bit last_grant flag is updated at each grant.
- Grant: the winner's addr/wen/wdata are latched into the mem_* registers (inst: wen=0). Next state is *_ADDR, with mem_req=1 from the next cycle.
- *_ADDR: hold mem_req=1 with stable payload until mem_addr_ok.
  - addr_ok alone: go to *_DATA, mem_req=0 next cycle.
  - addr_ok and data_ok in the same cycle: complete directly (treated as *_DATA completion).
  - data_ok without addr_ok: ignored.
- *_DATA: wait for mem_data_ok.
  - On data_ok: for reads, register mem_rdata into the owner's rdata (stores leave data_rdata unchanged).
  - Pulse the owner's done for exactly one cycle; go to IDLE.
  - addr_ok in this state is ignored.
- Latency, zero-wait memory: req at cycle 0 → mem_req cycle 1 → data_ok cycle 2 → done cycle 3. At most one transaction outstanding.
- rdata registers hold their value until the next read completion for that requester.
- stallreq = (inst_req & ~inst_done) | (data_req & ~data_done), combinational.
- A requester must not drop req before done; if it does, the transaction still completes and done still pulses.

Test Plan:
- Reset, then inst_req=1 with inst_addr=0xBFC00000; memory returns addr_ok in cycle 1 and data_ok with rdata 0x3C1D0001 in cycle 2 → mem_req high in cycle 1 only; inst_done pulses in cycle 3 with inst_rdata=0x3C1D0001; stallreq is high in cycles 0–2 and low in cycle 3.
- inst_req and data_req raised together (load at 0x80001000), both held → data granted first; inst granted in the IDLE cycle after data_done. Then, with both re-requesting, inst and data alternate.
- Store with data_wen=4'b0011, data_wdata=0x12345678, addr 0x80000004 → mem_wr=1, mem_wstrb=0011, payload stable for 3 cycles while addr_ok is withheld; data_done pulses once and data_rdata is unchanged.
- addr_ok and data_ok in the same cycle as the first mem_req → done pulses in the next cycle; the total is 2 cycles from grant.
- rst asserted while in I_DATA, then data_ok arrives after release → all outputs are 0 asynchronously; no inst_done pulse; state returns to IDLE and a new request is served normally.
